// File: rtl/alu_bist.sv
// Built-in self-test sequencer for the 32-bit alu: drives LFSR operands for every
// ctrl code, folds each response into a MISR and compares it with a golden signature.
module alu_bist #(
  parameter int unsigned VECS_PER_OP = 16,
  parameter logic [31:0] SEED_A      = 32'h0000_0001,
  parameter logic [31:0] SEED_B      = 32'hACE1_2468,
  parameter logic [31:0] GOLDEN_SIG  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] signature,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_res,
  input  logic        alu_cout,
  input  logic        alu_over,
  input  logic        alu_zero
);

  localparam logic [31:0] lfsr_poly = 32'h8020_0003;
  localparam logic [31:0] misr_poly = 32'h04C1_1DB7;
  localparam logic [15:0] last_vec  = 16'(VECS_PER_OP - 1);
  localparam logic [3:0]  last_op   = 4'd8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? lfsr_poly : 32'h0);
  endfunction

  function automatic logic [3:0] op_ctrl(input logic [3:0] idx);
    case (idx)
      4'd0:    return 4'b0010;  // add
      4'd1:    return 4'b0110;  // sub
      4'd2:    return 4'b0000;  // and
      4'd3:    return 4'b0001;  // or
      4'd4:    return 4'b0011;  // xor
      4'd5:    return 4'b0111;  // slt
      4'd6:    return 4'b0101;  // sltu
      4'd7:    return 4'b1000;  // sll
      4'd8:    return 4'b1001;  // srl
      default: return 4'b0000;
    endcase
  endfunction

  // Shift ops only see a 5-bit amount, so the upper operand bits are forced to zero.
  function automatic logic [31:0] shape_b(input logic [31:0] raw, input logic [3:0] ctrl);
    return (ctrl == 4'b1000 || ctrl == 4'b1001) ? {27'b0, raw[4:0]} : raw;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] lfsr_b_q, lfsr_b_d;
  logic [3:0]  op_q, op_d;
  logic [15:0] vec_q, vec_d;
  logic [31:0] alu_a_d, alu_b_d, sig_d, misr_next;
  logic [3:0]  alu_ctrl_d;
  logic        busy_d, done_d, pass_d;

  assign misr_next = {signature[30:0], 1'b0} ^ (signature[31] ? misr_poly : 32'h0)
                   ^ alu_res ^ {29'b0, alu_cout, alu_over, alu_zero};

  // NOTE: every variable gets a default at the top of always_comb so no path leaves
  // it unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a;
    lfsr_b_d   = lfsr_b_q;
    alu_b_d    = alu_b;
    alu_ctrl_d = alu_ctrl;
    op_d       = op_q;
    vec_d      = vec_q;
    sig_d      = signature;
    busy_d     = busy;
    done_d     = done;
    pass_d     = pass;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RUN;
          alu_a_d    = SEED_A;
          lfsr_b_d   = SEED_B;
          op_d       = 4'd0;
          vec_d      = 16'd0;
          alu_ctrl_d = op_ctrl(4'd0);
          alu_b_d    = shape_b(SEED_B, alu_ctrl_d);
          sig_d      = 32'h0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
        end
      end
      RUN: begin
        sig_d    = misr_next;
        alu_a_d  = lfsr_step(alu_a);
        lfsr_b_d = lfsr_step(lfsr_b_q);
        if (vec_q == last_vec) begin
          vec_d = 16'd0;
          if (op_q == last_op) begin
            op_d    = 4'd0;
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (misr_next == GOLDEN_SIG);
          end else begin
            op_d = op_q + 4'd1;
          end
        end else begin
          vec_d = vec_q + 16'd1;
        end
        alu_ctrl_d = op_ctrl(op_d);
        alu_b_d    = shape_b(lfsr_b_d, alu_ctrl_d);
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      alu_a     <= 32'h0;
      lfsr_b_q  <= 32'h0;
      alu_b     <= 32'h0;
      alu_ctrl  <= 4'b0000;
      op_q      <= 4'd0;
      vec_q     <= 16'd0;
      signature <= 32'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_a     <= alu_a_d;
      lfsr_b_q  <= lfsr_b_d;
      alu_b     <= alu_b_d;
      alu_ctrl  <= alu_ctrl_d;
      op_q      <= op_d;
      vec_q     <= vec_d;
      signature <= sig_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist: a stuck-at-zero alu on the default build and a
// constant-one alu on two single-vector builds with matching and mismatching goldens.
module tb_alu_bist;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;

  logic [31:0] res0 = 32'h0;
  logic [31:0] res1 = 32'h1;
  logic        flag0 = 1'b0;

  logic        busy0, done0, pass0;
  logic [31:0] sig0, a0, b0;
  logic [3:0]  ctrl0;
  logic        busy1, done1, pass1;
  logic [31:0] sig1, a1, b1;
  logic [3:0]  ctrl1;
  logic        busy2, done2, pass2;
  logic [31:0] sig2, a2, b2;
  logic [3:0]  ctrl2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_bist dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .busy(busy0), .done(done0), .pass(pass0), .signature(sig0),
    .alu_a(a0), .alu_b(b0), .alu_ctrl(ctrl0),
    .alu_res(res0), .alu_cout(flag0), .alu_over(flag0), .alu_zero(flag0)
  );

  alu_bist #(.VECS_PER_OP(1), .GOLDEN_SIG(32'h0000_01FF)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .busy(busy1), .done(done1), .pass(pass1), .signature(sig1),
    .alu_a(a1), .alu_b(b1), .alu_ctrl(ctrl1),
    .alu_res(res1), .alu_cout(flag0), .alu_over(flag0), .alu_zero(flag0)
  );

  alu_bist #(.VECS_PER_OP(1), .GOLDEN_SIG(32'h0000_0000)) dut2 (
    .clk(clk), .rst(rst), .start(start1),
    .busy(busy2), .done(done2), .pass(pass2), .signature(sig2),
    .alu_a(a2), .alu_b(b2), .alu_ctrl(ctrl2),
    .alu_res(res1), .alu_cout(flag0), .alu_over(flag0), .alu_zero(flag0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lfsr_model(input logic [31:0] x);
    logic [31:0] y;
    y = {1'b0, x[31:1]};
    if (x[0]) y = y ^ 32'h8020_0003;
    return y;
  endfunction

  task automatic check_reset0(input string tag);
    check({tag, "_busy"}, 32'(busy0), 32'd0);
    check({tag, "_done"}, 32'(done0), 32'd0);
    check({tag, "_pass"}, 32'(pass0), 32'd0);
    check({tag, "_ctrl"}, 32'(ctrl0), 32'd0);
    check({tag, "_a"},    a0,         32'd0);
    check({tag, "_b"},    b0,         32'd0);
    check({tag, "_sig"},  sig0,       32'd0);
  endtask

  task automatic check_first0(input string tag);
    check({tag, "_busy"}, 32'(busy0), 32'd1);
    check({tag, "_done"}, 32'(done0), 32'd0);
    check({tag, "_a"},    a0,         32'h0000_0001);
    check({tag, "_b"},    b0,         32'hACE1_2468);
    check({tag, "_ctrl"}, 32'(ctrl0), 32'h2);
    check({tag, "_sig"},  sig0,       32'h0);
  endtask

  logic [3:0]  ops [9] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011,
                           4'b0111, 4'b0101, 4'b1000, 4'b1001};
  logic [31:0] mb, exp_b;
  int          k, op;

  initial begin
    // Reset then idle.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_reset0("rst0");
    check("rst1_sig", sig1, 32'h0);
    check("rst1_done", 32'(done1), 32'd0);

    // Full default run against a stuck-at-zero alu, with a stray start mid-run.
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check_first0("first");
    mb = 32'hACE1_2468;
    k  = 0;
    while (busy0 && k < 400) begin
      if (k < 144) begin
        op    = k / 16;
        exp_b = (op >= 7) ? {27'b0, mb[4:0]} : mb;
        check($sformatf("ctrl_k%0d", k), 32'(ctrl0), 32'(ops[op]));
        check($sformatf("b_k%0d", k), b0, exp_b);
      end
      if (k == 1) check("a_step1", a0, 32'h8020_0003);
      start0 = (k == 50);
      tick();
      mb = lfsr_model(mb);
      k++;
    end
    start0 = 1'b0;
    check("busy_cycles", 32'(k), 32'd144);
    check("run0_done", 32'(done0), 32'd1);
    check("run0_busy", 32'(busy0), 32'd0);
    check("run0_sig", sig0, 32'h0);
    check("run0_pass", 32'(pass0), 32'd1);
    tick();
    check("run0_done_held", 32'(done0), 32'd1);

    // Single-vector builds with a constant-one result.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("seq_ctrl%0d", i), 32'(ctrl1), 32'(ops[i]));
      check($sformatf("seq_busy%0d", i), 32'(busy1), 32'd1);
      tick();
    end
    check("one_busy", 32'(busy1), 32'd0);
    check("one_done", 32'(done1), 32'd1);
    check("one_sig", sig1, 32'h0000_01FF);
    check("one_pass", 32'(pass1), 32'd1);
    check("bad_sig", sig2, 32'h0000_01FF);
    check("bad_done", 32'(done2), 32'd1);
    check("bad_pass", 32'(pass2), 32'd0);

    // Restart from DONE, reset at cycle 70 together with start (reset wins).
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check_first0("restart");
    repeat (69) tick();
    check("mid_busy", 32'(busy0), 32'd1);
    rst    = 1'b1;
    start0 = 1'b1;
    tick();
    rst    = 1'b0;
    start0 = 1'b0;
    check_reset0("midrst");
    check("midrst1_done", 32'(done1), 32'd0);
    check("midrst1_pass", 32'(pass1), 32'd0);
    check("midrst1_sig", sig1, 32'h0);
    tick();
    check_reset0("idle_after");

    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check_first0("again");
    tick();
    check("again_a1", a0, 32'h8020_0003);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
